branch_resolve_unit: RTL

Fetch-to-execute companion of the branch predictor/BTB block: carries each fetched instruction's prediction through IF/ID and ID/EX, checks it against the EX-stage outcome, and produces the predictor/BTB update strobes plus a pipeline redirect. It drives the update interface of the predictor/BTB block and is fed by that block's access outputs.

---
 rtl/branch_resolve_unit.sv | 87 ++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries fetch-time predictions to EX, checks them against the resolved outcome, and drives predictor/BTB updates and redirects.
module branch_resolve_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_pc,
  input  logic                  if_hit,
  input  logic                  if_pred,
  input  logic [DATA_WIDTH-1:0] if_target,
  input  logic                  stall,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic                  ex_is_jump,
  input  logic                  ex_taken,
  input  logic [DATA_WIDTH-1:0] ex_target,
  output logic                  update_predictor,
  output logic                  update_btb,
  output logic                  actually_taken,
  output logic [DATA_WIDTH-1:0] resolved_pc,
  output logic [DATA_WIDTH-1:0] resolved_pc_target,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count,
  output logic                  proto_err
);
  logic                  ifid_valid, idex_valid;
  logic [DATA_WIDTH-1:0] ifid_pc, ifid_pnext, idex_pc, idex_pnext;
  logic [DATA_WIDTH-1:0] fetch_pnext, anext;
  logic                  res, tk, is_cf, mis, proto;
  always_comb begin
    fetch_pnext = (if_hit & if_pred) ? if_target : if_pc + DATA_WIDTH'(4);
    tk          = ex_taken | ex_is_jump;
    is_cf       = ex_is_branch | ex_is_jump;
    anext       = tk ? ex_target : idex_pc + DATA_WIDTH'(4);
    res         = ex_valid & ~redirect & idex_valid;
    proto       = ex_valid & ~redirect & ~idex_valid;
    mis         = res & (anext != idex_pnext);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifid_valid         <= 1'b0;
      ifid_pc            <= '0;
      ifid_pnext         <= '0;
      idex_valid         <= 1'b0;
      idex_pc            <= '0;
      idex_pnext         <= '0;
      update_predictor   <= 1'b0;
      update_btb         <= 1'b0;
      actually_taken     <= 1'b0;
      resolved_pc        <= '0;
      resolved_pc_target <= '0;
      redirect           <= 1'b0;
      redirect_pc        <= '0;
      branch_count       <= '0;
      mispredict_count   <= '0;
      proto_err          <= 1'b0;
    end else begin
      if (mis) begin
        ifid_valid <= 1'b0;
        idex_valid <= 1'b0;
      end else if (!stall) begin
        idex_valid <= ifid_valid;
        idex_pc    <= ifid_pc;
        idex_pnext <= ifid_pnext;
        ifid_valid <= if_valid & ~redirect;
        ifid_pc    <= if_pc;
        ifid_pnext <= fetch_pnext;
      end
      update_predictor <= res & ex_is_branch;
      update_btb       <= res & is_cf & tk;
      redirect         <= mis;
      if (res) begin
        actually_taken     <= tk;
        resolved_pc        <= idex_pc;
        resolved_pc_target <= ex_target;
        redirect_pc        <= anext;
      end
      if (proto) proto_err <= 1'b1;
      if (res & is_cf & ~&branch_count) branch_count <= branch_count + 1'b1;
      if (mis & ~&mispredict_count) mispredict_count <= mispredict_count + 1'b1;
    end
  end
endmodule
